// File: rtl/instr_serializer_pkg.sv
// Shared types and constants for the instruction write-side serializer.
// The state encoding is fixed so the fetch path can decode the same values.
package instr_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        BYTE2 = 2'd3
    } state_e;

    localparam logic [7:0] LONG_OPCODE = 8'h18;
    localparam int         BYTE_W      = 8;

endpackage

// File: rtl/rom_write_pointer.sv
// Bit-addressed ROM pointer: clears to the start address and advances one byte per strobe.
// Wrap-around at 2^PTR_W is silent; the same block is reused by the fetch side.
module rom_write_pointer #(
    parameter int PTR_W = 9,
    parameter int START = 0,
    parameter int STEP  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W-1:0] o_ptr_nxt
);

    localparam logic [PTR_W-1:0] START_PTR = PTR_W'(START);
    localparam logic [PTR_W-1:0] STEP_PTR  = PTR_W'(STEP);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    assign w_ptr_nxt = r_ptr + STEP_PTR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= START_PTR;
        end else if (i_inc) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign o_ptr     = r_ptr;
    assign o_ptr_nxt = w_ptr_nxt;

endmodule

// File: rtl/instr_serializer.sv
// Splits 32-bit instruction words into 1 or 3 bytes (MSB first) and writes them
// to consecutive bit-addressed ROM locations; byte [7:0] of a word is never stored.
module instr_serializer
    import instr_serializer_pkg::*;
#(
    parameter int         size_for_fetch       = BYTE_W,
    parameter int         size_for_out_bus     = 32,
    parameter int         start_address_of_rom = 0,
    parameter int         size_of_pointer      = 9,
    parameter int         addr_step            = 8,
    parameter logic [7:0] long_opcode          = LONG_OPCODE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_from_source,
    input  logic [size_for_out_bus-1:0] data_from_source,
    output logic                        ready_for_source,
    output logic [size_for_fetch-1:0]   data_for_memory,
    output logic                        write_enable,
    output logic [size_of_pointer-1:0]  address_for_memory,
    input  logic                        ready_from_memory,
    output logic [15:0]                 instr_count
);

    localparam int F      = size_for_fetch;
    localparam int KEEP_W = 2 * F;
    localparam int LSB_W  = size_for_out_bus - 3 * F;
    localparam logic [size_of_pointer-1:0] START_PTR = size_of_pointer'(start_address_of_rom);

    state_e                     r_state;
    logic                       r_long;
    logic [KEEP_W-1:0]          r_word;
    logic                       r_rdy;
    logic                       r_we;
    logic [F-1:0]               r_data;
    logic [size_of_pointer-1:0] r_addr;
    logic [15:0]                r_cnt;

    logic                       w_accept;
    logic [size_of_pointer-1:0] w_ptr;
    logic [size_of_pointer-1:0] w_ptr_nxt;
    logic                       w_unused_lsb;

    // Only bytes 1 and 2 need to be kept; byte 0 goes straight to the output.
    assign w_unused_lsb = ^data_from_source[LSB_W-1:0];
    assign w_accept     = (r_state != IDLE) && ready_from_memory;

    rom_write_pointer #(
        .PTR_W (size_of_pointer),
        .START (start_address_of_rom),
        .STEP  (addr_step)
    ) u_ptr (
        .clk       (clk),
        .rst_n     (reset),
        .i_inc     (w_accept),
        .o_ptr     (w_ptr),
        .o_ptr_nxt (w_ptr_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_long  <= 1'b0;
            r_word  <= '0;
            r_rdy   <= 1'b1;
            r_we    <= 1'b0;
            r_data  <= '0;
            r_addr  <= START_PTR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_from_source) begin
                        r_word  <= data_from_source[size_for_out_bus-F-1 -: KEEP_W];
                        r_long  <= (data_from_source[size_for_out_bus-1 -: F] == long_opcode);
                        r_data  <= data_from_source[size_for_out_bus-1 -: F];
                        r_addr  <= w_ptr;
                        r_we    <= 1'b1;
                        r_rdy   <= 1'b0;
                        r_state <= BYTE0;
                    end
                end
                BYTE0: begin
                    if (ready_from_memory) begin
                        if (r_long) begin
                            r_data  <= r_word[KEEP_W-1 -: F];
                            r_addr  <= w_ptr_nxt;
                            r_state <= BYTE1;
                        end else begin
                            r_we    <= 1'b0;
                            r_rdy   <= 1'b1;
                            r_cnt   <= r_cnt + 16'd1;
                            r_state <= IDLE;
                        end
                    end
                end
                BYTE1: begin
                    if (ready_from_memory) begin
                        r_data  <= r_word[F-1:0];
                        r_addr  <= w_ptr_nxt;
                        r_state <= BYTE2;
                    end
                end
                BYTE2: begin
                    // Completion lands in IDLE, so a start on this edge waits one cycle.
                    if (ready_from_memory) begin
                        r_we    <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_for_source   = r_rdy;
    assign write_enable       = r_we;
    assign data_for_memory    = r_data;
    assign address_for_memory = r_addr;
    assign instr_count        = r_cnt;

endmodule

// File: tb/tb_instr_serializer.sv
// Bench for instr_serializer: fixed vector table, hand-built corner sequences and
// random words checked against a byte/address model of the serialization rules.
module tb_instr_serializer;

    logic        clk;
    logic        reset;
    logic        start_from_source;
    logic [31:0] data_from_source;
    logic        ready_for_source;
    logic [7:0]  data_for_memory;
    logic        write_enable;
    logic [8:0]  address_for_memory;
    logic        ready_from_memory;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    logic [15:0] model_count = 16'd0;

    typedef struct {
        logic [31:0] word;
        int          stall_at;
        int          stall_n;
        int          exp_n;
        logic [23:0] exp_b;
    } vec_t;

    vec_t tbl[8];

    instr_serializer dut (
        .clk                (clk),
        .reset              (reset),
        .start_from_source  (start_from_source),
        .data_from_source   (data_from_source),
        .ready_for_source   (ready_for_source),
        .data_for_memory    (data_for_memory),
        .write_enable       (write_enable),
        .address_for_memory (address_for_memory),
        .ready_from_memory  (ready_from_memory),
        .instr_count        (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start_from_source = 1'b0;
        data_from_source = 32'h0;
        ready_from_memory = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_ptr = 0;
        model_count = 16'd0;
    endtask

    // Drives one word and checks every write cycle against the expected byte stream.
    task automatic send(input string tag, input logic [31:0] w, input int stall_at,
                        input int stall_n, input int exp_n, input logic [23:0] exp_b);
        int k, st, guard;
        logic [7:0] eb;
        @(negedge clk);
        start_from_source = 1'b1;
        data_from_source  = w;
        ready_from_memory = 1'b1;
        @(negedge clk);
        start_from_source = 1'b0;
        k = 0; st = 0; guard = 0;
        while (k < exp_n && guard < 40) begin
            eb = 8'(exp_b >> (16 - 8 * k));
            chk({tag, ".we"}, 32'(write_enable), 32'd1);
            chk({tag, ".data"}, 32'(data_for_memory), 32'(eb));
            chk({tag, ".addr"}, 32'(address_for_memory), 32'((model_ptr + 8 * k) % 512));
            chk({tag, ".rdy_src"}, 32'(ready_for_source), 32'd0);
            if (k == stall_at && st < stall_n) begin
                ready_from_memory = 1'b0;
                st++;
            end else begin
                ready_from_memory = 1'b1;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        model_ptr   = (model_ptr + 8 * exp_n) % 512;
        model_count = model_count + 16'd1;
        chk({tag, ".we_done"}, 32'(write_enable), 32'd0);
        chk({tag, ".rdy_done"}, 32'(ready_for_source), 32'd1);
        chk({tag, ".count"}, 32'(instr_count), 32'(model_count));
    endtask

    initial begin
        logic [31:0] w;
        int n;

        reset = 1'b0;
        start_from_source = 1'b0;
        data_from_source = 32'h0;
        ready_from_memory = 1'b1;
        #12;
        chk("reset.rdy", 32'(ready_for_source), 32'd1);
        chk("reset.we", 32'(write_enable), 32'd0);
        chk("reset.data", 32'(data_for_memory), 32'd0);
        chk("reset.addr", 32'(address_for_memory), 32'd0);
        chk("reset.count", 32'(instr_count), 32'd0);
        do_reset();

        tbl[0] = '{32'h05AABBCC, -1, 0, 1, 24'h050000};
        tbl[1] = '{32'h18112233, -1, 0, 3, 24'h181122};
        tbl[2] = '{32'h18112233,  1, 3, 3, 24'h181122};
        tbl[3] = '{32'h17FFFFFF,  0, 2, 1, 24'h170000};
        tbl[4] = '{32'h19123456, -1, 0, 1, 24'h190000};
        tbl[5] = '{32'h18000000,  2, 1, 3, 24'h180000};
        tbl[6] = '{32'h00000001, -1, 0, 1, 24'h000000};
        tbl[7] = '{32'h18FEDCBA,  0, 1, 3, 24'h18FEDC};
        for (int i = 0; i < 8; i++)
            send($sformatf("tbl%0d", i), tbl[i].word, tbl[i].stall_at, tbl[i].stall_n,
                 tbl[i].exp_n, tbl[i].exp_b);

        // Wrap: 64 short words from 0 end at 504, the 65th lands on 0 again.
        do_reset();
        for (int i = 0; i < 65; i++)
            send($sformatf("wrap%0d", i), {8'h40 + 8'(i), 24'hABCDEF}, -1, 0, 1,
                 {8'h40 + 8'(i), 16'h0000});

        // Reset in the middle of a long word.
        do_reset();
        @(negedge clk);
        start_from_source = 1'b1;
        data_from_source  = 32'h18ABCDEF;
        ready_from_memory = 1'b1;
        @(negedge clk);
        start_from_source = 1'b0;
        @(negedge clk);
        chk("rst_mid.data_b1", 32'(data_for_memory), 32'hAB);
        chk("rst_mid.addr_b1", 32'(address_for_memory), 32'd8);
        ready_from_memory = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.we", 32'(write_enable), 32'd0);
        chk("rst_mid.addr", 32'(address_for_memory), 32'd0);
        chk("rst_mid.count", 32'(instr_count), 32'd0);
        chk("rst_mid.rdy", 32'(ready_for_source), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        ready_from_memory = 1'b1;
        model_ptr = 0;
        model_count = 16'd0;
        send("rst_mid.next", 32'h2A000000, -1, 0, 1, 24'h2A0000);

        // start held high across a long word: one capture, then one IDLE cycle.
        do_reset();
        @(negedge clk);
        start_from_source = 1'b1;
        data_from_source  = 32'h18A1B2C3;
        ready_from_memory = 1'b1;
        @(negedge clk);
        chk("hold.b0", 32'(data_for_memory), 32'h18);
        @(negedge clk);
        chk("hold.b1", 32'(data_for_memory), 32'hA1);
        chk("hold.a1", 32'(address_for_memory), 32'd8);
        @(negedge clk);
        chk("hold.b2", 32'(data_for_memory), 32'hB2);
        @(negedge clk);
        chk("hold.idle_we", 32'(write_enable), 32'd0);
        chk("hold.idle_rdy", 32'(ready_for_source), 32'd1);
        chk("hold.count1", 32'(instr_count), 32'd1);
        @(negedge clk);
        chk("hold.recap_we", 32'(write_enable), 32'd1);
        chk("hold.recap_addr", 32'(address_for_memory), 32'd24);
        start_from_source = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold.count2", 32'(instr_count), 32'd2);
        chk("hold.we_end", 32'(write_enable), 32'd0);
        @(negedge clk);
        chk("hold.no_third", 32'(write_enable), 32'd0);

        // Random words against the model: long iff opcode 0x18, bytes MSB first.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:24] = 8'h18;
            n = (w[31:24] == 8'h18) ? 3 : 1;
            send($sformatf("rnd%0d", i), w, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), n, w[31:8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
